// File: rtl/pwm_capture_pkg.sv
// ============================================================================
//  Module   : pwm_capture_pkg
//  Purpose  : Shared register map, status bit positions and helpers for the
//             PWM duty-cycle capture block.
//  Revision : 1.0
// ============================================================================
`default_nettype none

package pwm_capture_pkg;

    localparam int c_ADR_W = 8;
    localparam int c_DAT_W = 32;

    localparam logic [7:0] c_DUTY_BASE = 8'h00;
    localparam logic [7:0] c_STAT_BASE = 8'h10;

    localparam int c_FRESH = 0;
    localparam int c_STUCK = 1;

    typedef enum logic [1:0] {
        REG_DUTY = 2'd0,
        REG_STAT = 2'd1,
        REG_NONE = 2'd2
    } reg_sel_e;

    function automatic reg_sel_e decode_sel(input logic [7:0] adr);
        if (adr[7:4] == c_DUTY_BASE[7:4])
            return REG_DUTY;
        else if (adr[7:4] == c_STAT_BASE[7:4])
            return REG_STAT;
        else
            return REG_NONE;
    endfunction

    // A full window of high samples counts to 256, which must read back as 255.
    function automatic logic [7:0] sat8(input logic [8:0] v);
        return v[8] ? 8'hFF : v[7:0];
    endfunction

endpackage

`default_nettype wire

// File: rtl/pwm_capture_if.sv
// ============================================================================
//  Module   : iWishbone
//  Purpose  : Single-clock Wishbone-style register bus with peripheral and
//             controller views.
//  Revision : 1.0
// ============================================================================
`default_nettype none

interface iWishbone
    import pwm_capture_pkg::*;
(
    input logic clk,
    input logic rst
);

    logic               stb;
    logic               we;
    logic [c_ADR_W-1:0] adr;
    logic [c_DAT_W-1:0] dat_c;
    logic [c_DAT_W-1:0] dat_p;
    logic               ack;

    modport mPeri (
        input  clk, rst, stb, we, adr, dat_c,
        output dat_p, ack
    );

    modport mCtrl (
        input  clk, rst, dat_p, ack,
        output stb, we, adr, dat_c
    );

endinterface

`default_nettype wire

// File: rtl/pwm_capture_channel.sv
// ============================================================================
//  Module   : pwm_capture_channel
//  Purpose  : One capture lane: input synchronizer, edge detect, high-time
//             counter and duty/fresh/stuck result registers.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module pwm_capture_channel
    import pwm_capture_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       pwm_in,
    input  logic       tick,
    input  logic       win_end,
    input  logic       clr_fresh,
    output logic [7:0] duty,
    output logic       fresh,
    output logic       stuck
);

    logic       r_sync1;
    logic       r_sync2;
    logic       r_prev;
    logic [8:0] r_high;
    logic       r_edge_seen;
    logic [7:0] r_duty;
    logic       r_fresh;
    logic       r_stuck;

    logic       w_rise;
    logic [8:0] w_high_next;

    assign w_rise      = r_sync2 & ~r_prev;
    assign w_high_next = r_high + {8'd0, r_sync2};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1     <= 1'b0;
            r_sync2     <= 1'b0;
            r_prev      <= 1'b0;
            r_high      <= 9'd0;
            r_edge_seen <= 1'b0;
            r_duty      <= 8'd0;
            r_fresh     <= 1'b0;
            r_stuck     <= 1'b0;
        end else begin
            r_sync1 <= pwm_in;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;

            // Window end is always a tick, so the current sample is folded in here.
            if (win_end) begin
                r_duty      <= sat8(w_high_next);
                r_high      <= 9'd0;
                r_stuck     <= ~r_edge_seen;
                r_edge_seen <= w_rise;
            end else begin
                if (tick)
                    r_high <= w_high_next;
                if (w_rise)
                    r_edge_seen <= 1'b1;
            end

            if (win_end)
                r_fresh <= 1'b1;
            else if (clr_fresh)
                r_fresh <= 1'b0;
        end
    end

    assign duty  = r_duty;
    assign fresh = r_fresh;
    assign stuck = r_stuck;

endmodule

`default_nettype wire

// File: rtl/pwm_capture.sv
// ============================================================================
//  Module   : pwm_capture
//  Purpose  : Multi-channel PWM duty-cycle capture with a shared step timebase
//             and a read-only register bus.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module pwm_capture
    import pwm_capture_pkg::*;
#(
    parameter int pWbHz     = 0,
    parameter int pInHz     = 0,
    parameter int pChannels = 0
) (
    iWishbone.mPeri         wb,
    input logic [pChannels-1:0] pwm_in
);

    localparam int lpChMax        = 16;
    localparam int lpRatio        = pWbHz / ((pInHz > 0) ? pInHz : 1);
    localparam int lpTicksPerStep = (lpRatio >= 256) ? (lpRatio / 256) : 1;
    localparam int lpPreW         = (lpTicksPerStep > 1) ? $clog2(lpTicksPerStep) : 1;
    localparam logic [lpPreW-1:0] lpPreLast = lpPreW'(lpTicksPerStep - 1);

    logic [lpPreW-1:0]  r_pre;
    logic [7:0]         r_step;
    logic               r_ack;
    logic [c_DAT_W-1:0] r_dat;

    logic               w_tick;
    logic               w_win_end;
    logic               w_first;
    reg_sel_e           w_sel;
    logic [3:0]         w_ch;
    logic [c_DAT_W-1:0] w_rd;
    logic [7:0]         w_duty [lpChMax];
    logic [lpChMax-1:0] w_fresh;
    logic [lpChMax-1:0] w_stuck;
    logic               w_unused;

    assign w_tick    = (r_pre == lpPreLast);
    assign w_win_end = w_tick && (r_step == 8'hFF);
    assign w_sel     = decode_sel(wb.adr);
    assign w_ch      = wb.adr[3:0];
    assign w_first   = wb.stb & ~r_ack & ~wb.we;
    assign w_unused  = ^wb.dat_c;

    always_ff @(posedge wb.clk or posedge wb.rst) begin
        if (wb.rst) begin
            r_pre  <= '0;
            r_step <= 8'd0;
        end else if (w_tick) begin
            r_pre  <= '0;
            r_step <= r_step + 8'd1;
        end else begin
            r_pre  <= r_pre + lpPreW'(1);
        end
    end

    // Unpopulated slots read as zero so the address decode never needs a range check.
    generate
        for (genvar ch = 0; ch < lpChMax; ch++) begin : g_ch
            if (ch < pChannels) begin : g_inst
                pwm_capture_channel u_chan (
                    .clk       (wb.clk),
                    .rst       (wb.rst),
                    .pwm_in    (pwm_in[ch]),
                    .tick      (w_tick),
                    .win_end   (w_win_end),
                    .clr_fresh (w_first && (w_sel == REG_STAT) && (w_ch == 4'(ch))),
                    .duty      (w_duty[ch]),
                    .fresh     (w_fresh[ch]),
                    .stuck     (w_stuck[ch])
                );
            end else begin : g_tie
                assign w_duty[ch]  = 8'd0;
                assign w_fresh[ch] = 1'b0;
                assign w_stuck[ch] = 1'b0;
            end
        end
    endgenerate

    always_comb begin
        w_rd = '0;
        case (w_sel)
            REG_DUTY: w_rd[7:0] = w_duty[w_ch];
            REG_STAT: begin
                w_rd[c_FRESH] = w_fresh[w_ch];
                w_rd[c_STUCK] = w_stuck[w_ch];
            end
            default: w_rd = '0;
        endcase
    end

    // Read data is captured from the registers before any same-edge update lands.
    always_ff @(posedge wb.clk or posedge wb.rst) begin
        if (wb.rst) begin
            r_ack <= 1'b0;
            r_dat <= '0;
        end else begin
            r_ack <= wb.stb;
            r_dat <= (wb.stb && !wb.we) ? w_rd : '0;
        end
    end

    assign wb.ack   = r_ack;
    assign wb.dat_p = r_dat;

endmodule

`default_nettype wire

// File: tb/tb_pwm_capture.sv
// ============================================================================
//  Module   : tb_pwm_capture
//  Purpose  : Directed scoreboard bench for pwm_capture with four PWM sources.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_pwm_capture;
    import pwm_capture_pkg::*;

    localparam int WB_HZ  = 25_600_000;
    localparam int IN_HZ  = 1000;
    localparam int NCH    = 4;
    localparam int PERIOD = 25600;

    typedef struct {
        int unsigned lo;
        int unsigned hi;
        string       tag;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [NCH-1:0] pwm_in;
    int             high_clks [NCH];
    int             gcnt;
    int unsigned    rel_clks;
    exp_t           sb [$];
    exp_t           e;
    int             n_checks = 0;
    int             n_errors = 0;

    iWishbone wb (.clk(clk), .rst(rst));

    pwm_capture #(
        .pWbHz     (WB_HZ),
        .pInHz     (IN_HZ),
        .pChannels (NCH)
    ) dut (
        .wb     (wb),
        .pwm_in (pwm_in)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst) rel_clks <= 0;
        else     rel_clks <= rel_clks + 1;
    end

    // PWM sources: high for the first high_clks[i] clocks of each period.
    initial begin
        gcnt   = 0;
        pwm_in = '0;
        forever begin
            @(negedge clk);
            if (rst) gcnt = 0;
            else     gcnt = (gcnt == PERIOD - 1) ? 0 : gcnt + 1;
            for (int i = 0; i < NCH; i++)
                pwm_in[i] = (gcnt < high_clks[i]);
        end
    end

    always @(negedge clk) begin
        if (wb.ack === 1'b1 && wb.we === 1'b0) begin
            n_checks++;
            if (sb.size() == 0) begin
                n_errors++;
                $error("FAIL unexpected_ack: observed dat_p %0d with no pending read", wb.dat_p);
            end else begin
                e = sb.pop_front();
                assert ((wb.dat_p >= 32'(e.lo)) && (wb.dat_p <= 32'(e.hi))) else begin
                    n_errors++;
                    $error("FAIL %s: observed %0d expected %0d..%0d", e.tag, wb.dat_p, e.lo, e.hi);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    task automatic chk(input logic [31:0] obs, input logic [31:0] expv, input string tag);
        n_checks++;
        assert (obs === expv) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    // Caller must be just after a negedge; stb is sampled on the next posedge.
    task automatic bus(input logic w, input logic [7:0] a, input int cycles);
        wb.stb   = 1'b1;
        wb.we    = w;
        wb.adr   = a;
        wb.dat_c = 32'hA5A5_5A5A;
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            chk({31'd0, wb.ack}, 32'd1, "ack_high");
        end
        #1;
        wb.stb = 1'b0;
        wb.we  = 1'b0;
        @(negedge clk);
        chk({31'd0, wb.ack}, 32'd0, "ack_low");
        #1;
    endtask

    task automatic rd(input logic [7:0] a, input int unsigned lo, input int unsigned hi,
                      input string tag);
        sb.push_back('{lo: lo, hi: hi, tag: tag});
        bus(1'b0, a, 1);
    endtask

    initial begin
        high_clks[0] = 6400;
        high_clks[1] = PERIOD;
        high_clks[2] = 0;
        high_clks[3] = 12800;
        wb.stb   = 1'b0;
        wb.we    = 1'b0;
        wb.adr   = 8'h00;
        wb.dat_c = '0;

        repeat (3) @(negedge clk);
        chk({31'd0, wb.ack}, 32'd0, "reset_ack");
        chk(wb.dat_p, 32'd0, "reset_dat");
        #1 rst = 1'b0;

        // Partial window, then a mid-window reset that must discard it.
        wait_clks(2);
        bus(1'b1, 8'h00, 1);
        rd(8'h00, 0, 0, "duty0_after_write");
        rd(8'h20, 0, 0, "unmapped_20");
        rd(8'h14, 0, 0, "unpopulated_14");
        rd(8'hFF, 0, 0, "unmapped_ff");
        wait_clks(5000);

        rst    = 1'b1;
        wb.stb = 1'b1;
        wb.adr = 8'h13;
        repeat (3) begin
            @(negedge clk);
            chk({31'd0, wb.ack}, 32'd0, "rst_mid_ack");
            chk(wb.dat_p, 32'd0, "rst_mid_dat");
        end
        #1 wb.stb = 1'b0;
        @(negedge clk);
        #1 rst = 1'b0;

        // Held read sampled on the 25600th and 25601st clocks after release.
        wait_clks(25599);
        sb.push_back('{lo: 0, hi: 0, tag: "st3_window_end_edge"});
        sb.push_back('{lo: 1, hi: 1, tag: "st3_after_window_end"});
        bus(1'b0, 8'h13, 2);

        rd(8'h13, 1, 1, "st3_w1_first");
        rd(8'h13, 0, 0, "st3_w1_second");
        rd(8'h03, 127, 129, "duty3_w1");
        rd(8'h01, 255, 255, "duty1_w1");
        rd(8'h02, 0, 0, "duty2_w1");
        rd(8'h12, 3, 3, "st2_w1");
        rd(8'h11, 1, 1, "st1_w1");
        high_clks[3] = 3200;
        rd(8'h10, 1, 1, "st0_w1_first");
        rd(8'h10, 0, 0, "st0_w1_second");

        while (rel_clks < 51205) @(negedge clk);
        #1;
        bus(1'b1, 8'h13, 1);
        rd(8'h13, 1, 1, "st3_w2_after_write");
        rd(8'h00, 63, 65, "duty0_w2");
        rd(8'h10, 1, 1, "st0_w2");
        rd(8'h01, 255, 255, "duty1_w2");
        rd(8'h11, 3, 3, "st1_w2");
        rd(8'h02, 0, 0, "duty2_w2");
        rd(8'h12, 3, 3, "st2_w2");
        rd(8'h03, 31, 33, "duty3_w2");

        wait_clks(2);
        chk(32'(sb.size()), 32'd0, "scoreboard_drain");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
